// File: rtl/onehot_state_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : onehot_state_reg_pkg
// Purpose  : Shared mARC control constants, state indices and legality helper.
// Revision : 1.0 - initial release
// ============================================================================
package onehot_state_reg_pkg;

    localparam int N_STATES = 13;

    localparam int IF   = 0;
    localparam int ID   = 1;
    localparam int RF   = 2;
    localparam int EX   = 3;
    localparam int MEM  = 4;
    localparam int WB   = 5;
    localparam int BR   = 6;
    localparam int LD   = 7;
    localparam int ST   = 8;
    localparam int MUL  = 9;
    localparam int DIV  = 10;
    localparam int EXC  = 11;
    localparam int HALT = 12;

    // Exactly one bit set; narrower vectors are zero-extended by the caller.
    function automatic logic is_onehot(input logic [63:0] v);
        return (v != 64'd0) && ((v & (v - 64'd1)) == 64'd0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/onehot_state_reg_onehot_to_bin.sv
`default_nettype none
// ============================================================================
// Module   : onehot_to_bin
// Purpose  : One-hot to binary index encoder; lowest set bit wins, 0 if none.
// Revision : 1.0 - initial release
// ============================================================================
module onehot_to_bin #(
    parameter int N_STATES = 13,
    parameter int IDX_W    = 4
) (
    input  logic [N_STATES-1:0] oh,
    output logic [IDX_W-1:0]    idx
);

    // Scan high to low so the lowest set bit is the last one written.
    always_comb begin
        idx = '0;
        for (int i = N_STATES - 1; i >= 0; i--) begin
            if (oh[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/onehot_state_reg.sv
`default_nettype none
// ============================================================================
// Module   : onehot_state_reg
// Purpose  : One-hot state register with trap-on-illegal, history, dwell and
//            error tracking.
// Revision : 1.0 - initial release
// ============================================================================
module onehot_state_reg #(
    parameter int N_STATES    = onehot_state_reg_pkg::N_STATES,
    parameter int RESET_STATE = 0,
    parameter int TRAP_STATE  = 0,
    parameter int DWELL_W     = 8,
    localparam int IDX_W      = ($clog2(N_STATES) < 1) ? 1 : $clog2(N_STATES)
) (
    input  logic                clk,
    input  logic                preset,
    input  logic                en,
    input  logic                clr_err,
    input  logic [N_STATES-1:0] d,
    output logic [N_STATES-1:0] q,
    output logic [N_STATES-1:0] q_prev,
    output logic [IDX_W-1:0]    q_idx,
    output logic                changed,
    output logic [DWELL_W-1:0]  dwell,
    output logic                illegal,
    output logic                err,
    output logic [7:0]          err_cnt
);
    import onehot_state_reg_pkg::*;

    localparam logic [N_STATES-1:0] c_reset_vec = N_STATES'(1) << RESET_STATE;
    localparam logic [N_STATES-1:0] c_trap_vec  = N_STATES'(1) << TRAP_STATE;
    localparam logic [DWELL_W-1:0]  c_dwell_max = {DWELL_W{1'b1}};

    logic [N_STATES-1:0] r_q;
    logic [N_STATES-1:0] r_q_prev;
    logic                r_changed;
    logic [DWELL_W-1:0]  r_dwell;
    logic                r_err;
    logic [7:0]          r_err_cnt;

    logic                w_illegal;
    logic                w_trap;
    logic [N_STATES-1:0] w_q_next;
    logic                w_q_chg;

    assign w_illegal = !is_onehot(64'(d));
    assign w_trap    = en && w_illegal;
    assign w_q_next  = !en ? r_q : (w_illegal ? c_trap_vec : d);
    assign w_q_chg   = (w_q_next != r_q);

    always_ff @(posedge clk or posedge preset) begin
        if (preset) begin
            r_q       <= c_reset_vec;
            r_q_prev  <= c_reset_vec;
            r_changed <= 1'b0;
            r_dwell   <= '0;
            r_err     <= 1'b0;
            r_err_cnt <= 8'd0;
        end else begin
            r_q       <= w_q_next;
            r_changed <= w_q_chg;
            if (w_q_chg) begin
                r_q_prev <= r_q;
                r_dwell  <= '0;
            end else if (r_dwell != c_dwell_max) begin
                r_dwell  <= r_dwell + 1'b1;
            end
            // A fresh illegal transition takes priority over a coincident clear.
            if (w_trap) begin
                r_err <= 1'b1;
                if (clr_err) begin
                    r_err_cnt <= 8'd1;
                end else if (r_err_cnt != 8'hFF) begin
                    r_err_cnt <= r_err_cnt + 8'd1;
                end
            end else if (clr_err) begin
                r_err     <= 1'b0;
                r_err_cnt <= 8'd0;
            end
        end
    end

    onehot_to_bin #(
        .N_STATES (N_STATES),
        .IDX_W    (IDX_W)
    ) u_enc (
        .oh  (r_q),
        .idx (q_idx)
    );

    assign q       = r_q;
    assign q_prev  = r_q_prev;
    assign changed = r_changed;
    assign dwell   = r_dwell;
    assign illegal = w_illegal;
    assign err     = r_err;
    assign err_cnt = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_onehot_state_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_onehot_state_reg
// Purpose  : Directed self-checking bench for onehot_state_reg (default params).
// Revision : 1.0 - initial release
// ============================================================================
module tb_onehot_state_reg;

    logic        clk;
    logic        preset;
    logic        en;
    logic        clr_err;
    logic [12:0] d;
    logic [12:0] q;
    logic [12:0] q_prev;
    logic [3:0]  q_idx;
    logic        changed;
    logic [7:0]  dwell;
    logic        illegal;
    logic        err;
    logic [7:0]  err_cnt;

    int checks = 0;
    int errors = 0;

    onehot_state_reg dut (
        .clk     (clk),
        .preset  (preset),
        .en      (en),
        .clr_err (clr_err),
        .d       (d),
        .q       (q),
        .q_prev  (q_prev),
        .q_idx   (q_idx),
        .changed (changed),
        .dwell   (dwell),
        .illegal (illegal),
        .err     (err),
        .err_cnt (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        preset  = 1'b1;
        en      = 1'b0;
        clr_err = 1'b0;
        d       = 13'h0000;
        #3;
        chk("por_q", q, 13'h0001);
        chk("por_err_cnt", err_cnt, 8'd0);
        preset = 1'b0;

        // Build up non-reset state, then preset it away mid-cycle.
        en = 1'b1; d = 13'h0004; tick();
        chk("pre_q", q, 13'h0004);
        d = 13'h0000; tick();
        chk("pre_err", err, 1'b1);
        chk("pre_err_cnt", err_cnt, 8'd1);
        en = 1'b0; tick(); tick();
        chk("pre_dwell", dwell, 8'd2);
        #2 preset = 1'b1;
        #1;
        chk("rst_q", q, 13'h0001);
        chk("rst_q_prev", q_prev, 13'h0001);
        chk("rst_q_idx", q_idx, 4'd0);
        chk("rst_dwell", dwell, 8'd0);
        chk("rst_err", err, 1'b0);
        chk("rst_err_cnt", err_cnt, 8'd0);
        chk("rst_changed", changed, 1'b0);
        preset = 1'b0;

        // Legal walk
        en = 1'b1; d = 13'h0001; tick();
        chk("walk0_q", q, 13'h0001);
        chk("walk0_changed", changed, 1'b0);
        chk("walk0_dwell", dwell, 8'd1);
        d = 13'h0002; tick();
        chk("walk1_q", q, 13'h0002);
        chk("walk1_changed", changed, 1'b1);
        chk("walk1_q_prev", q_prev, 13'h0001);
        chk("walk1_q_idx", q_idx, 4'd1);
        chk("walk1_dwell", dwell, 8'd0);
        d = 13'h0010; tick();
        chk("walk2_q", q, 13'h0010);
        chk("walk2_changed", changed, 1'b1);
        chk("walk2_q_prev", q_prev, 13'h0002);
        chk("walk2_q_idx", q_idx, 4'd4);
        en = 1'b0; tick();
        chk("walk3_changed", changed, 1'b0);
        chk("walk3_dwell", dwell, 8'd1);

        // Hold with illegal d presented
        d = 13'h0003;
        #1;
        chk("hold_illegal", illegal, 1'b1);
        for (int i = 0; i < 300; i++) tick();
        chk("hold_q", q, 13'h0010);
        chk("hold_q_prev", q_prev, 13'h0002);
        chk("hold_err", err, 1'b0);
        chk("hold_err_cnt", err_cnt, 8'd0);
        chk("hold_dwell", dwell, 8'd255);
        chk("hold_changed", changed, 1'b0);

        // Illegal transitions trap to state 0
        en = 1'b1; d = 13'h0000;
        #1;
        chk("ill0_illegal", illegal, 1'b1);
        tick();
        chk("ill0_q", q, 13'h0001);
        chk("ill0_q_prev", q_prev, 13'h0010);
        chk("ill0_changed", changed, 1'b1);
        chk("ill0_dwell", dwell, 8'd0);
        chk("ill0_err", err, 1'b1);
        chk("ill0_err_cnt", err_cnt, 8'd1);
        d = 13'h0006;
        #1;
        chk("ill1_illegal", illegal, 1'b1);
        tick();
        chk("ill1_q", q, 13'h0001);
        chk("ill1_changed", changed, 1'b0);
        chk("ill1_q_prev", q_prev, 13'h0010);
        chk("ill1_err_cnt", err_cnt, 8'd2);
        d = 13'h1000;
        #1;
        chk("legal_illegal", illegal, 1'b0);

        // Clear racing an illegal transition
        clr_err = 1'b1; d = 13'h1800; tick();
        chk("race_err", err, 1'b1);
        chk("race_err_cnt", err_cnt, 8'd1);
        d = 13'h0008; tick();
        chk("clr_err", err, 1'b0);
        chk("clr_err_cnt", err_cnt, 8'd0);
        chk("clr_q", q, 13'h0008);
        chk("clr_q_idx", q_idx, 4'd3);
        clr_err = 1'b0;

        // Counter saturation
        d = 13'h0003;
        for (int i = 0; i < 255; i++) tick();
        chk("sat255_err_cnt", err_cnt, 8'd255);
        chk("sat255_dwell", dwell, 8'd254);
        chk("sat255_q_prev", q_prev, 13'h0008);
        for (int i = 0; i < 5; i++) tick();
        chk("sat260_err_cnt", err_cnt, 8'd255);
        chk("sat260_err", err, 1'b1);
        chk("sat260_q", q, 13'h0001);
        chk("sat260_dwell", dwell, 8'd255);

        // Plain clear while disabled
        en = 1'b0; clr_err = 1'b1; tick();
        chk("fin_err", err, 1'b0);
        chk("fin_err_cnt", err_cnt, 8'd0);
        clr_err = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
